chunked_magnitude_comparator: RTL

Parametrised multi-cycle magnitude comparator that takes two WIDTH-bit operands through a valid/ready handshake. It compares them most-significant chunk first, CHUNK bits per cycle, and stops early at the first chunk that differs. It returns a registered eq/gt/lt result through an output valid/ready handshake. Signed (two's complement) and unsigned comparison are selected per transaction. It replaces the single-cycle 4-bit comparator wherever wide operands would otherwise break timing.

---
 rtl/chunked_magnitude_comparator.sv | 121 ++++++++++++
 1 files changed

// File: rtl/chunked_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB chunk first, CHUNK bits
// per cycle, stopping at the first differing chunk; eq/gt/lt returned via valid/ready.
module chunked_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               signed_q, signed_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;

    logic [WIDTH-1:0]   a_cmp, b_cmp;
    logic [CHUNK-1:0]   chunk_a, chunk_b;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign a_cmp   = a_q ^ {signed_q, {(WIDTH-1){1'b0}}};
    assign b_cmp   = b_q ^ {signed_q, {(WIDTH-1){1'b0}}};
    assign chunk_a = a_cmp[CHUNK*int'(idx_q) +: CHUNK];
    assign chunk_b = b_cmp[CHUNK*int'(idx_q) +: CHUNK];

    // NOTE: every next-state variable gets its default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    signed_d = signed_mode;
                    idx_d    = IDX_W'(NCHUNK - 1);
                    state_d  = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (chunk_a > chunk_b) begin
                    {eq_d, gt_d, lt_d} = 3'b010;
                    state_d            = S_DONE;
                end else if (chunk_a < chunk_b) begin
                    {eq_d, gt_d, lt_d} = 3'b001;
                    state_d            = S_DONE;
                end else if (idx_q == '0) begin
                    {eq_d, gt_d, lt_d} = 3'b100;
                    state_d            = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign lt        = lt_q;

endmodule
